data_check: RTL and testbench
=============================

Name: data_check

Overview:
- Receive-side counterpart of the PAM4 pattern generator.
- Consumes 2-bit PAM4 symbols from the demodulator and hunts for the frame head 3,0,3,0,3,0.
- After the head, self-synchronises to the PRBS payload, then reports per-cycle bit errors, cumulative error/bit counts and lock status.
- Sits after the symbol slicer in the RX path; its counters feed the BER readout logic.

Parameters:
INV_PATTERN, 1, 1 = payload is the inverted PRBS (predict with XNOR); 0 = XOR
POLY_LENGHT, 9, PRBS polynomial length n in x^n + x^t + 1
POLY_TAP, 5, PRBS polynomial tap t
CNT_W, 32, width of bit_count and err_count
LOCK_WINDOW, 256, symbols per lock-monitor window
LOSS_THRESH, 16, bit errors within one window that force loss of lock

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
check_enable  in  1  level; leave IDLE and start hunting
check_stop  in  1  level; return to IDLE
data_in  in  2  received symbol; bit 1 is the earlier bit in time, bit 0 the later
locked  out  1  high while in CHECK
header_det  out  1  one-cycle pulse when a head is recognised
err_flag  out  1  one-cycle pulse: at least one bit error in the checked symbol
lock_lost  out  1  one-cycle pulse on LOSS_THRESH exit from CHECK
bit_count  out  CNT_W  payload bits checked, saturating
err_count  out  CNT_W  payload bit errors, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, head shift register 0, history 0, window counters 0.
- All outputs are registered. Each output reflects the symbol sampled on the previous edge (1-cycle latency).
- States: IDLE, HUNT, SYNC, CHECK.
- IDLE: counts held, not cleared. check_enable=1 moves to HUNT next edge.
- HUNT: 6-symbol sliding register, oldest first. When it equals 3,0,3,0,3,0 including the current sample:
  - header_det pulses.
  - bit_count and err_count clear to 0.
  - Next state is SYNC.
- SYNC: shifts ceil(POLY_LENGHT/2) symbols (5 by default) into history, no checking, then moves to CHECK. locked rises on the first CHECK cycle.
- History h[k] holds the received bit k+1 positions earlier. It is always loaded with received bits, never predicted bits (self-synchronising).
- Prediction, early bit: p1 = h[POLY_LENGHT-1] op h[POLY_TAP-1].
- Prediction, late bit: p0 = h[POLY_LENGHT-2] op h[POLY_TAP-2].
- op is XNOR when INV_PATTERN=1, XOR otherwise. Errors are e1 = data_in[1]^p1 and e0 = data_in[0]^p0.
- CHECK, per symbol:
  - bit_count += 2.
  - err_count += e1+e0.
  - err_flag = e1|e0.
  - Both counters saturate at all-ones.
- One isolated channel bit error yields exactly 3 counted errors, inherent to self-sync checking.
- Lock monitor in CHECK:
  - Window symbol counter and window error accumulator.
  - When accumulated errors reach ≥ LOSS_THRESH: lock_lost pulses, locked falls, state goes to HUNT, window counters clear.
  - After LOCK_WINDOW symbols: window counters clear.
  - If the window end and the threshold fall on the same symbol, the threshold wins.
- check_stop=1 forces IDLE from any state and has priority over header match and lock loss. It clears locked and window counters but holds the counts.
- check_enable and check_stop both high: IDLE.
- Async rst mid-operation: immediate return to reset values, no pulse emitted.
- HUNT ignores errors. A PRBS run that mimics the head while in HUNT is accepted as a head.

Test Plan:
1. Reset then idle: rst pulse with data_in random and check_enable=0 -> all outputs 0, counts stay 0 for 100 cycles.
2. Clean frame: check_enable=1, 10 symbols of 0, head 3,0,3,0,3,0, then 1000 symbols of inverted PRBS9 (x^9+x^5+1, 2 bits/symbol, early bit on data_in[1]) -> header_det pulses once; locked high 5 payload symbols later; err_count=0; bit_count=1990.
3. Single flip: as scenario 2, with data_in[1] of payload symbol 400 inverted -> err_count=3; err_flag pulses on 2 or 3 cycles (2 when errors share a symbol); locked stays 1.
4. Burst: as scenario 2, with every bit inverted-randomised for 20 symbols mid-payload -> lock_lost pulses, locked=0, state HUNT. Then a new head and clean PRBS -> header_det, counts restart from 0, relock, err_count=0 afterwards.
5. Stop/priority: in CHECK, assert check_stop on the same cycle as an errored symbol -> IDLE next cycle, locked=0, counts frozen at their prior values. With check_enable=1 held alongside check_stop -> remains IDLE.
6. Async reset: assert rst between clock edges mid-CHECK -> outputs 0 immediately without waiting for an edge. After release plus enable, a fresh head relocks normally.

Source files
------------

// File: rtl/data_check.sv
// PAM4 PRBS receive checker: hunts the 3,0,3,0,3,0 frame head, self-synchronises to the
// payload, then counts checked bits and bit errors and watches for loss of lock.
module data_check #(
  parameter int unsigned INV_PATTERN = 1,
  parameter int unsigned POLY_LENGHT = 9,
  parameter int unsigned POLY_TAP    = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LOCK_WINDOW = 256,
  parameter int unsigned LOSS_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_enable,
  input  logic             check_stop,
  input  logic [1:0]       data_in,
  output logic             locked,
  output logic             header_det,
  output logic             err_flag,
  output logic             lock_lost,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned SyncLen = (POLY_LENGHT + 1) / 2;
  localparam int unsigned SyncW   = $clog2(SyncLen + 1);
  localparam int unsigned WinW    = $clog2(LOCK_WINDOW + 1);
  localparam int unsigned AccW    = $clog2(LOSS_THRESH + 2);
  localparam logic        InvBit  = (INV_PATTERN != 0);
  localparam logic [11:0] HeadPat = 12'b11_00_11_00_11_00;

  typedef enum logic [1:0] {StIdle, StHunt, StSync, StCheck} state_e;

  state_e                 r_state, w_state_d;
  logic [9:0]             r_head, w_head_d;
  logic [POLY_LENGHT-1:0] r_hist;
  logic [SyncW-1:0]       r_sync_cnt, w_sync_d;
  logic [WinW-1:0]        r_win_cnt, w_win_cnt_d;
  logic [AccW-1:0]        r_win_err, w_win_err_d;
  logic [CNT_W-1:0]       r_bit_count, w_bit_d;
  logic [CNT_W-1:0]       r_err_count, w_err_d;
  logic                   r_locked, r_header_det, r_err_flag, r_lock_lost;
  logic                   w_hdr_d, w_errf_d, w_lost_d;

  logic [11:0]            w_head_win;
  logic                   w_p1, w_p0, w_e1, w_e0;
  logic [1:0]             w_nerr;
  logic [CNT_W:0]         w_bit_sum, w_err_sum;
  logic [CNT_W-1:0]       w_bit_sat, w_err_sat;
  logic [AccW-1:0]        w_win_err_sum;
  logic                   w_thresh, w_win_end;

  // Window of the last six symbols, current sample in the low bits.
  assign w_head_win = {r_head, data_in};

  // Prediction from received history only, so the checker self-synchronises.
  assign w_p1 = r_hist[POLY_LENGHT-1] ^ r_hist[POLY_TAP-1] ^ InvBit;
  assign w_p0 = r_hist[POLY_LENGHT-2] ^ r_hist[POLY_TAP-2] ^ InvBit;
  assign w_e1 = data_in[1] ^ w_p1;
  assign w_e0 = data_in[0] ^ w_p0;
  assign w_nerr = {1'b0, w_e1} + {1'b0, w_e0};

  assign w_bit_sum = {1'b0, r_bit_count} + (CNT_W+1)'(2);
  assign w_err_sum = {1'b0, r_err_count} + (CNT_W+1)'(w_nerr);
  assign w_bit_sat = w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
  assign w_err_sat = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];

  assign w_win_err_sum = r_win_err + AccW'(w_nerr);
  assign w_thresh      = (w_win_err_sum >= AccW'(LOSS_THRESH));
  assign w_win_end     = (r_win_cnt == WinW'(LOCK_WINDOW - 1));

  always_comb begin
    w_state_d   = r_state;
    w_head_d    = '0;
    w_sync_d    = r_sync_cnt;
    w_win_cnt_d = r_win_cnt;
    w_win_err_d = r_win_err;
    w_bit_d     = r_bit_count;
    w_err_d     = r_err_count;
    w_hdr_d     = 1'b0;
    w_errf_d    = 1'b0;
    w_lost_d    = 1'b0;
    if (check_stop) begin
      w_state_d   = StIdle;
      w_win_cnt_d = '0;
      w_win_err_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (check_enable) w_state_d = StHunt;
        end
        StHunt: begin
          w_head_d = w_head_win[9:0];
          if (w_head_win == HeadPat) begin
            w_hdr_d   = 1'b1;
            w_bit_d   = '0;
            w_err_d   = '0;
            w_sync_d  = '0;
            w_head_d  = '0;
            w_state_d = StSync;
          end
        end
        StSync: begin
          if (r_sync_cnt == SyncW'(SyncLen - 1)) begin
            w_sync_d  = '0;
            w_state_d = StCheck;
          end else begin
            w_sync_d = r_sync_cnt + 1'b1;
          end
        end
        StCheck: begin
          w_bit_d  = w_bit_sat;
          w_err_d  = w_err_sat;
          w_errf_d = w_e1 | w_e0;
          // Threshold takes precedence over a coincident window end.
          if (w_thresh) begin
            w_lost_d    = 1'b1;
            w_state_d   = StHunt;
            w_win_cnt_d = '0;
            w_win_err_d = '0;
          end else if (w_win_end) begin
            w_win_cnt_d = '0;
            w_win_err_d = '0;
          end else begin
            w_win_cnt_d = r_win_cnt + 1'b1;
            w_win_err_d = w_win_err_sum;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_head       <= '0;
      r_hist       <= '0;
      r_sync_cnt   <= '0;
      r_win_cnt    <= '0;
      r_win_err    <= '0;
      r_bit_count  <= '0;
      r_err_count  <= '0;
      r_locked     <= 1'b0;
      r_header_det <= 1'b0;
      r_err_flag   <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_head       <= w_head_d;
      r_hist       <= {r_hist[POLY_LENGHT-3:0], data_in[1], data_in[0]};
      r_sync_cnt   <= w_sync_d;
      r_win_cnt    <= w_win_cnt_d;
      r_win_err    <= w_win_err_d;
      r_bit_count  <= w_bit_d;
      r_err_count  <= w_err_d;
      r_locked     <= (w_state_d == StCheck);
      r_header_det <= w_hdr_d;
      r_err_flag   <= w_errf_d;
      r_lock_lost  <= w_lost_d;
    end
  end

  assign locked     = r_locked;
  assign header_det = r_header_det;
  assign err_flag   = r_err_flag;
  assign lock_lost  = r_lock_lost;
  assign bit_count  = r_bit_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: clean frame, single flip, burst/relock, stop priority
// and asynchronous reset, all against hand-computed expectations.
module tb_data_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        check_enable;
  logic        check_stop;
  logic [1:0]  data_in;
  logic        locked;
  logic        header_det;
  logic        err_flag;
  logic        lock_lost;
  logic [31:0] bit_count;
  logic [31:0] err_count;

  int n_vec  = 0;
  int n_miss = 0;
  int n_hdr, n_errf, n_lost, lock_idx;
  logic [8:0] r_prbs;

  always #5 clk = ~clk;

  data_check #(
    .INV_PATTERN(1),
    .POLY_LENGHT(9),
    .POLY_TAP   (5),
    .CNT_W      (32),
    .LOCK_WINDOW(256),
    .LOSS_THRESH(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .check_enable(check_enable),
    .check_stop  (check_stop),
    .data_in     (data_in),
    .locked      (locked),
    .header_det  (header_det),
    .err_flag    (err_flag),
    .lock_lost   (lock_lost),
    .bit_count   (bit_count),
    .err_count   (err_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_hdr    = 0;
    n_errf   = 0;
    n_lost   = 0;
    lock_idx = -1;
    r_prbs   = 9'h0A5;
  endtask

  // Apply one symbol; outputs are sampled 1 time unit after the capturing edge.
  task automatic send(input logic [1:0] sym);
    data_in = sym;
    @(posedge clk);
    #1;
    if (header_det === 1'b1) n_hdr++;
    if (err_flag === 1'b1) n_errf++;
    if (lock_lost === 1'b1) n_lost++;
  endtask

  // Inverted PRBS9 (x^9+x^5+1), earlier bit on data_in[1].
  task automatic next_sym(output logic [1:0] sym);
    logic b;
    for (int i = 0; i < 2; i++) begin
      b      = r_prbs[8] ^ r_prbs[4];
      r_prbs = {r_prbs[7:0], b};
      sym[1-i] = ~b;
    end
  endtask

  task automatic send_head();
    repeat (10) send(2'd0);
    for (int i = 0; i < 3; i++) begin
      send(2'd3);
      send(2'd0);
    end
  endtask

  task automatic send_payload(input int n, input int flip_idx, input int burst_lo,
                              input int burst_hi);
    logic [1:0] s;
    for (int i = 0; i < n; i++) begin
      next_sym(s);
      if (i == flip_idx) s[1] = ~s[1];
      if (i >= burst_lo && i <= burst_hi) s = ~s;
      send(s);
      if (locked === 1'b1 && lock_idx < 0) lock_idx = i;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    check_enable = 1'b0;
    check_stop   = 1'b0;
    data_in      = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    logic [1:0] s;
    clear_stats();

    // 1: reset then idle with random data
    rst          = 1'b1;
    check_enable = 1'b0;
    check_stop   = 1'b0;
    data_in      = 2'($urandom_range(0, 3));
    #3;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_bitcnt", bit_count, 0);
    check_eq("rst_errcnt", err_count, 0);
    check_eq("rst_pulses", {header_det, err_flag, lock_lost}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) send(2'($urandom_range(0, 3)));
    check_eq("idle_locked", locked, 0);
    check_eq("idle_bitcnt", bit_count, 0);
    check_eq("idle_errcnt", err_count, 0);
    check_eq("idle_pulses", n_hdr + n_errf + n_lost, 0);

    // 2: clean frame
    do_reset();
    check_enable = 1'b1;
    send_head();
    send_payload(1000, -1, -1, -1);
    check_eq("clean_hdr", n_hdr, 1);
    check_eq("clean_lockidx", lock_idx, 4);
    check_eq("clean_errcnt", err_count, 0);
    check_eq("clean_bitcnt", bit_count, 1990);
    check_eq("clean_errflag", n_errf, 0);
    check_eq("clean_locked", locked, 1);

    // 3: single flipped early bit in payload symbol 400
    do_reset();
    check_enable = 1'b1;
    send_head();
    send_payload(1000, 400, -1, -1);
    check_eq("flip_errcnt", err_count, 3);
    check_eq("flip_errflag", n_errf, 3);
    check_eq("flip_locked", locked, 1);
    check_eq("flip_lost", n_lost, 0);
    check_eq("flip_bitcnt", bit_count, 1990);

    // 4: 20-symbol fully inverted burst, then a fresh head and relock
    do_reset();
    check_enable = 1'b1;
    send_head();
    send_payload(600, -1, 500, 519);
    repeat (30) send(2'd0);
    check_eq("burst_lost", (n_lost > 0), 1);
    check_eq("burst_locked", locked, 0);
    clear_stats();
    send_head();
    send_payload(200, -1, -1, -1);
    check_eq("relock_hdr", n_hdr, 1);
    check_eq("relock_bitcnt", bit_count, 390);
    check_eq("relock_errcnt", err_count, 0);
    check_eq("relock_locked", locked, 1);
    check_eq("relock_idx", lock_idx, 4);

    // 5: stop coincident with an errored symbol, then enable+stop held
    do_reset();
    check_enable = 1'b1;
    send_head();
    send_payload(100, -1, -1, -1);
    check_eq("pre_stop_bitcnt", bit_count, 190);
    next_sym(s);
    check_stop = 1'b1;
    send(~s);
    check_eq("stop_locked", locked, 0);
    check_eq("stop_bitcnt", bit_count, 190);
    check_eq("stop_errcnt", err_count, 0);
    check_eq("stop_errflag", err_flag, 0);
    clear_stats();
    send_head();
    check_eq("stop_hold_hdr", n_hdr, 0);
    check_eq("stop_hold_locked", locked, 0);
    check_eq("stop_hold_bitcnt", bit_count, 190);
    check_stop = 1'b0;

    // 6: asynchronous reset between edges mid-check
    do_reset();
    check_enable = 1'b1;
    send_head();
    send_payload(100, -1, -1, -1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_locked", locked, 0);
    check_eq("arst_bitcnt", bit_count, 0);
    check_eq("arst_errcnt", err_count, 0);
    check_eq("arst_pulses", {header_det, err_flag, lock_lost}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    send_head();
    send_payload(100, -1, -1, -1);
    check_eq("arst_relock_hdr", n_hdr, 1);
    check_eq("arst_relock_bitcnt", bit_count, 190);
    check_eq("arst_relock_errcnt", err_count, 0);
    check_eq("arst_relock_locked", locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
